phase_sequencer: RTL and testbench

Control-phase generator and instruction register for the 16-bit microprocessor. It drives the one-hot phase strobes `f`, `e1`, `e2` and `e3` into the instruction decoder, and holds the fetched instruction on `instr` for the decoder's `INSTR` input. It is upstream of the decoder and consumes the instruction-memory read data. It runs a variable number of execute phases per opcode, halts on STP, and supports an external stall.

---
 rtl/phase_sequencer.sv | 141 ++++++++++++++
 tb/tb_phase_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - control-phase generator and instruction register
module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic [15:0]      instr_q,
  output logic [15:0]      instr,
  output logic             f,
  output logic             e1,
  output logic             e2,
  output logic             e3,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F,
    S_FW,
    S_E1,
    S_E2,
    S_E3,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             f_q, f_d;
  logic             e1_q, e1_d;
  logic             e2_q, e2_d;
  logic             e3_q, e3_d;
  logic             halted_q, halted_d;
  logic             busy_q, busy_d;

  logic [4:0]       op5;
  logic [1:0]       n_phases;
  logic             is_stp;

  // Decode the number of execute phases from the held instruction's opcode.
  always_comb begin
    op5      = ir_q[15:11];
    is_stp   = (op5 == 5'b00000);
    n_phases = 2'd1;
    if ((op5 == 5'b00010) || (op5 == 5'b00101) || (op5 == 5'b01000) ||
        (op5[4:2] == 3'b101) || (op5[4:3] == 2'b11)) begin
      n_phases = 2'd3;
    end else if (op5 == 5'b00111) begin
      n_phases = 2'd2;
    end
  end

  // Next-state, instruction-register load, retire count and strobe decode.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_F;
      S_F:    state_d = S_FW;
      S_FW: begin
        state_d = S_E1;
        ir_d    = instr_q;
      end
      S_E1: begin
        if (!stall) begin
          if (n_phases == 2'd1) begin
            state_d   = is_stp ? S_HALT : S_F;
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = S_E2;
          end
        end
      end
      S_E2: begin
        if (!stall) begin
          if (n_phases == 2'd2) begin
            state_d   = S_F;
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = S_E3;
          end
        end
      end
      S_E3: begin
        if (!stall) begin
          state_d   = S_F;
          retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_HALT: if (start) state_d = S_F;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered copies of the next state so they are glitch-free.
    f_d      = (state_d == S_F);
    e1_d     = (state_d == S_E1);
    e2_d     = (state_d == S_E2);
    e3_d     = (state_d == S_E3);
    halted_d = (state_d == S_HALT);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  // State and output registers; reset discards any in-flight instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= 16'h0000;
      retired_q <= '0;
      f_q       <= 1'b0;
      e1_q      <= 1'b0;
      e2_q      <= 1'b0;
      e3_q      <= 1'b0;
      halted_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      f_q       <= f_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      e3_q      <= e3_d;
      halted_q  <= halted_d;
      busy_q    <= busy_d;
    end
  end

  assign instr   = ir_q;
  assign f       = f_q;
  assign e1      = e1_q;
  assign e2      = e2_q;
  assign e3      = e3_q;
  assign halted  = halted_q;
  assign busy    = busy_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed table-driven bench for phase_sequencer
module tb_phase_sequencer;

  localparam int CNT_W = 8;

  logic             clock;
  logic             reset;
  logic             start;
  logic             stall;
  logic [15:0]      instr_q;
  logic [15:0]      instr;
  logic             f, e1, e2, e3;
  logic             halted, busy;
  logic [CNT_W-1:0] retired;

  phase_sequencer #(.CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .stall   (stall),
    .instr_q (instr_q),
    .instr   (instr),
    .f       (f),
    .e1      (e1),
    .e2      (e2),
    .e3      (e3),
    .halted  (halted),
    .busy    (busy),
    .retired (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] iv;
    int          nph;
    bit          stp;
    bit          stall_fetch;
  } vec_t;

  vec_t             vecs[11];
  int               checks = 0;
  int               passed = 0;
  logic [CNT_W-1:0] exp_ret = '0;
  logic [15:0]      prev_ir = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Entered at a negedge in the F cycle; leaves at the negedge after the last E phase.
  task automatic do_instr(input logic [15:0] iv, input int nph, input bit stp, input bit stall_fetch);
    instr_q = iv;
    stall   = stall_fetch;
    chk("f_cycle_strobes", {f, e1, e2, e3}, 4'b1000);
    chk("ir_hold_in_f", instr, prev_ir);
    step();
    chk("fw_strobes", {f, e1, e2, e3}, 4'b0000);
    chk("fw_busy", busy, 1'b1);
    chk("ir_hold_in_fw", instr, prev_ir);
    stall = 1'b0;
    step();
    chk("e1_strobes", {f, e1, e2, e3}, 4'b0100);
    chk("ir_load", instr, iv);
    if (nph >= 2) begin
      step();
      chk("e2_strobes", {f, e1, e2, e3}, 4'b0010);
    end
    if (nph >= 3) begin
      step();
      chk("e3_strobes", {f, e1, e2, e3}, 4'b0001);
    end
    chk("retired_before_last", retired, exp_ret);
    step();
    exp_ret = exp_ret + 1'b1;
    prev_ir = iv;
    if (stp) begin
      chk("halt_strobes", {f, e1, e2, e3}, 4'b0000);
      chk("halted_set", halted, 1'b1);
      chk("busy_in_halt", busy, 1'b0);
    end else begin
      chk("back_to_back_f", {f, e1, e2, e3}, 4'b1000);
      chk("not_halted", halted, 1'b0);
    end
    chk("retired_after", retired, exp_ret);
  endtask

  initial begin
    vecs[0]  = '{16'h8805, 1, 1'b0, 1'b0};  // ldi R1,#5
    vecs[1]  = '{16'h1000, 3, 1'b0, 1'b0};  // adm
    vecs[2]  = '{16'h3800, 2, 1'b0, 1'b0};  // mlr
    vecs[3]  = '{16'h2800, 3, 1'b0, 1'b1};  // sbm, stall held through F/FW
    vecs[4]  = '{16'h4000, 3, 1'b0, 1'b0};  // mlm
    vecs[5]  = '{16'hA000, 3, 1'b0, 1'b0};  // sta
    vecs[6]  = '{16'hC800, 3, 1'b0, 1'b0};  // sti
    vecs[7]  = '{16'hE000, 3, 1'b0, 1'b0};  // lda
    vecs[8]  = '{16'h6000, 1, 1'b0, 1'b0};  // other op5 01100
    vecs[9]  = '{16'h3000, 1, 1'b0, 1'b0};  // op5 00110, single phase
    vecs[10] = '{16'h0000, 1, 1'b1, 1'b0};  // stp

    reset   = 1'b1;
    start   = 1'b0;
    stall   = 1'b0;
    instr_q = 16'h0000;
    step();
    step();
    chk("reset_strobes", {f, e1, e2, e3}, 4'b0000);
    chk("reset_instr", instr, 16'h0000);
    chk("reset_halted", halted, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_retired", retired, 8'h00);
    reset = 1'b0;
    step();
    chk("idle_no_start", {f, busy}, 2'b00);

    start = 1'b1;
    step();
    start = 1'b0;
    foreach (vecs[i]) do_instr(vecs[i].iv, vecs[i].nph, vecs[i].stp, vecs[i].stall_fetch);

    // Halt persists without start; retired and instr frozen.
    repeat (4) begin
      step();
      chk("halt_hold", {halted, f, e1, e2, e3, busy}, 6'b100000);
      chk("halt_retired", retired, exp_ret);
      chk("halt_instr", instr, 16'h0000);
    end

    // start together with stall in HALT still leaves for F.
    start = 1'b1;
    stall = 1'b1;
    step();
    start = 1'b0;
    stall = 1'b0;
    chk("halt_exit_f", {f, halted, busy}, 3'b101);

    // adm stalled for three cycles starting in E2.
    instr_q = 16'h1000;
    step();
    step();
    chk("stall_e1", {f, e1, e2, e3}, 4'b0100);
    step();
    chk("stall_e2_first", {f, e1, e2, e3}, 4'b0010);
    stall = 1'b1;
    start = 1'b1;
    repeat (3) begin
      step();
      chk("stall_e2_hold", {f, e1, e2, e3}, 4'b0010);
      chk("stall_no_retire", retired, exp_ret);
      chk("stall_instr", instr, 16'h1000);
    end
    stall = 1'b0;
    start = 1'b0;
    step();
    chk("stall_e3", {f, e1, e2, e3}, 4'b0001);
    chk("stall_e3_retired", retired, exp_ret);
    step();
    exp_ret = exp_ret + 1'b1;
    chk("stall_then_f", {f, e1, e2, e3}, 4'b1000);
    chk("stall_retired_once", retired, exp_ret);

    // Reset during E2 of adm.
    step();
    step();
    step();
    chk("pre_reset_e2", {f, e1, e2, e3}, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ret = '0;
    prev_ir = 16'h0000;
    chk("mid_reset_strobes", {f, e1, e2, e3, halted, busy}, 6'b000000);
    chk("mid_reset_retired", retired, 8'h00);
    chk("mid_reset_instr", instr, 16'h0000);
    repeat (3) begin
      step();
      chk("post_reset_idle", {f, e1, e2, e3, halted, busy}, 6'b000000);
    end

    // Counter wrap: 255 ldi to reach all-ones, then one more to wrap.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (255) do_instr(16'h8805, 1, 1'b0, 1'b0);
    chk("retired_all_ones", retired, 8'hFF);
    do_instr(16'h8805, 1, 1'b0, 1'b0);
    chk("retired_wrap", retired, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
